// File: rtl/pipe_ctrl_pkg.sv
// Shared state encodings, counter width default and control-bundle constants
// for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned STATE_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN = 3'd0,
        ST_LU  = 3'd1,
        ST_MD  = 3'd2,
        ST_FL  = 3'd3,
        ST_HLT = 3'd4
    } state_e;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN   = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
    localparam ctrl_t CTRL_STALL = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
    localparam ctrl_t CTRL_REDIR = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0};
    localparam ctrl_t CTRL_HALT  = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones until reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: turns hazard requests into PC/IF-ID/ID-EX
// enables and flushes, and counts stall and flush events.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         bubble,
    input  logic               redirect,
    input  logic               md_busy,
    input  logic               halt,
    output logic               pc_we,
    output logic               ifid_we,
    output logic               ifid_flush,
    output logic               idex_flush,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;
    logic   stall_inc;
    logic   flush_inc;

    // Controls are decoded from the current state and live requests so a
    // request acts on the very edge that follows it.
    always_comb begin
        state_d = state_q;
        ctrl    = CTRL_RUN;
        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    ctrl    = CTRL_REDIR;
                    state_d = ST_FL;
                end else if (md_busy) begin
                    ctrl    = CTRL_STALL;
                    state_d = ST_MD;
                end else if (bubble != 2'd0) begin
                    ctrl    = CTRL_STALL;
                    state_d = ST_LU;
                end
            end
            ST_LU: begin
                if (redirect) begin
                    ctrl    = CTRL_REDIR;
                    state_d = ST_FL;
                end else begin
                    ctrl    = CTRL_STALL;
                    state_d = ST_RUN;
                end
            end
            ST_MD: begin
                if (redirect) begin
                    ctrl    = CTRL_REDIR;
                    state_d = ST_FL;
                end else if (md_busy) begin
                    ctrl    = CTRL_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FL: begin
                state_d = ST_RUN;
            end
            ST_HLT: begin
                ctrl = CTRL_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (halt) begin
            ctrl    = CTRL_HALT;
            state_d = ST_HLT;
        end
        if (rst) begin
            ctrl    = CTRL_RUN;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign pc_we      = ctrl.pc_we;
    assign ifid_we    = ctrl.ifid_we;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_flush = ctrl.idex_flush;
    assign state      = state_q;

    // A halted pipeline is not counted as stalling or flushing.
    assign stall_inc = !ctrl.pc_we && (state_q != ST_HLT);
    assign flush_inc = ctrl.ifid_flush && (state_q != ST_HLT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: scoreboard of expected per-cycle
// controls/state, plus counter checks on a default and a 4-bit instance.
module tb_pipe_stall_ctrl;

    localparam logic [2:0] S_RUN = 3'd0;
    localparam logic [2:0] S_LU  = 3'd1;
    localparam logic [2:0] S_MD  = 3'd2;
    localparam logic [2:0] S_FL  = 3'd3;
    localparam logic [2:0] S_HLT = 3'd4;

    // {pc_we, ifid_we, ifid_flush, idex_flush}
    localparam logic [3:0] O_RUN   = 4'b1100;
    localparam logic [3:0] O_STALL = 4'b0001;
    localparam logic [3:0] O_REDIR = 4'b1110;
    localparam logic [3:0] O_HALT  = 4'b0011;

    typedef struct packed {
        logic [3:0] ctl;
        logic [2:0] st;
    } exp_t;

    typedef struct packed {
        logic [1:0] b;
        logic       r;
        logic       m;
        logic       h;
        logic [3:0] ctl;
        logic [2:0] st;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  bubble;
    logic        redirect, md_busy, halt;
    logic        pc_we, ifid_we, ifid_flush, idex_flush;
    logic [2:0]  state;
    logic [15:0] stall_cnt, flush_cnt;
    logic        pc_we4, ifid_we4, ifid_flush4, idex_flush4;
    logic [2:0]  state4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int checks   = 0;
    int failures = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clk(clk), .rst(rst), .bubble(bubble), .redirect(redirect),
        .md_busy(md_busy), .halt(halt), .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stall_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bubble(bubble), .redirect(redirect),
        .md_busy(md_busy), .halt(halt), .pc_we(pc_we4), .ifid_we(ifid_we4),
        .ifid_flush(ifid_flush4), .idex_flush(idex_flush4), .state(state4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    function automatic stim_t mk(input logic [1:0] b, input logic r, input logic m,
                                 input logic h, input logic [3:0] ctl, input logic [2:0] st);
        return '{b: b, r: r, m: m, h: h, ctl: ctl, st: st};
    endfunction

    function automatic exp_t observed();
        return exp_t'({pc_we, ifid_we, ifid_flush, idex_flush, state});
    endfunction

    // Drive one cycle's requests at negedge, queue the expected pre-edge view.
    task automatic drive(input stim_t s);
        @(negedge clk);
        bubble = s.b; redirect = s.r; md_busy = s.m; halt = s.h;
        sb_q.push_back('{ctl: s.ctl, st: s.st});
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bubble = 2'd0; redirect = 1'b0; md_busy = 1'b0; halt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; bubble = 2'd3; redirect = 1'b1; md_busy = 1'b1; halt = 1'b1;
        #1;
        checks++;
        if ({pc_we, ifid_we, ifid_flush, idex_flush, state} !== {O_RUN, S_RUN}) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=%b", {pc_we, ifid_we, ifid_flush, idex_flush, state}, {O_RUN, S_RUN});
        end
        checks++;
        if ({pc_we4, ifid_we4, ifid_flush4, idex_flush4, state4} !== {O_RUN, S_RUN}) begin
            failures++;
            $display("FAIL reset_ctl4 got=%b exp=%b", {pc_we4, ifid_we4, ifid_flush4, idex_flush4, state4}, {O_RUN, S_RUN});
        end
        @(posedge clk); #1;
        checks++;
        if ({state, stall_cnt, flush_cnt, stall_cnt4, flush_cnt4} !== {S_RUN, 16'd0, 16'd0, 4'd0, 4'd0}) begin
            failures++;
            $display("FAIL reset_cnt got st=%0d s=%0d f=%0d s4=%0d f4=%0d exp all 0",
                     state, stall_cnt, flush_cnt, stall_cnt4, flush_cnt4);
        end
        @(negedge clk);
        rst = 1'b0; bubble = 2'd0; redirect = 1'b0; md_busy = 1'b0; halt = 1'b0;
    endtask

    task automatic test_bubble();
        stim_t seq [8];
        exp_t  e, g;
        do_reset();
        seq = '{mk(2'd0, 0, 0, 0, O_RUN,   S_RUN),
                mk(2'd1, 0, 0, 0, O_STALL, S_RUN),
                mk(2'd0, 0, 0, 0, O_STALL, S_LU),
                mk(2'd0, 0, 0, 0, O_RUN,   S_RUN),
                mk(2'd2, 0, 0, 0, O_STALL, S_RUN),
                mk(2'd2, 0, 0, 0, O_STALL, S_LU),
                mk(2'd2, 0, 0, 0, O_STALL, S_RUN),
                mk(2'd0, 0, 0, 0, O_STALL, S_LU)};
        for (int i = 0; i < 8; i++) begin
            drive(seq[i]);
            e = sb_q.pop_front();
            g = observed();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL bubble[%0d] got ctl=%b st=%0d exp ctl=%b st=%0d", i, g.ctl, g.st, e.ctl, e.st);
            end
            if (i == 3) begin
                checks++;
                if (stall_cnt !== 16'd2) begin
                    failures++;
                    $display("FAIL bubble_stall_cnt got=%0d exp=2", stall_cnt);
                end
            end
        end
        drive(mk(2'd0, 0, 0, 0, O_RUN, S_RUN));
        e = sb_q.pop_front();
        g = observed();
        checks++;
        if (g !== e || stall_cnt !== 16'd6 || flush_cnt !== 16'd0) begin
            failures++;
            $display("FAIL bubble_end got ctl=%b st=%0d s=%0d f=%0d exp ctl=%b st=%0d s=6 f=0",
                     g.ctl, g.st, stall_cnt, flush_cnt, e.ctl, e.st);
        end
    endtask

    task automatic test_md();
        stim_t seq [10];
        exp_t  e, g;
        do_reset();
        seq = '{mk(2'd0, 0, 1, 0, O_STALL, S_RUN),
                mk(2'd0, 0, 1, 0, O_STALL, S_MD),
                mk(2'd0, 0, 1, 0, O_STALL, S_MD),
                mk(2'd0, 0, 1, 0, O_STALL, S_MD),
                mk(2'd0, 0, 1, 0, O_STALL, S_MD),
                mk(2'd0, 0, 0, 0, O_RUN,   S_MD),
                mk(2'd0, 0, 0, 0, O_RUN,   S_RUN),
                mk(2'd1, 0, 1, 0, O_STALL, S_RUN),
                mk(2'd0, 0, 0, 0, O_RUN,   S_MD),
                mk(2'd0, 0, 0, 0, O_RUN,   S_RUN)};
        for (int i = 0; i < 10; i++) begin
            drive(seq[i]);
            e = sb_q.pop_front();
            g = observed();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL md[%0d] got ctl=%b st=%0d exp ctl=%b st=%0d", i, g.ctl, g.st, e.ctl, e.st);
            end
            if (i == 6) begin
                checks++;
                if (stall_cnt !== 16'd5) begin
                    failures++;
                    $display("FAIL md_stall_cnt got=%0d exp=5", stall_cnt);
                end
            end
        end
        checks++;
        if (stall_cnt !== 16'd6 || flush_cnt !== 16'd0) begin
            failures++;
            $display("FAIL md_end_cnt got s=%0d f=%0d exp s=6 f=0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_redirect();
        stim_t seq [11];
        exp_t  e, g;
        do_reset();
        seq = '{mk(2'd1, 1, 0, 0, O_REDIR, S_RUN),
                mk(2'd1, 0, 0, 0, O_RUN,   S_FL),
                mk(2'd0, 0, 0, 0, O_RUN,   S_RUN),
                mk(2'd0, 0, 1, 0, O_STALL, S_RUN),
                mk(2'd0, 1, 1, 0, O_REDIR, S_MD),
                mk(2'd0, 0, 1, 0, O_RUN,   S_FL),
                mk(2'd0, 0, 0, 0, O_RUN,   S_RUN),
                mk(2'd1, 0, 0, 0, O_STALL, S_RUN),
                mk(2'd1, 1, 0, 0, O_REDIR, S_LU),
                mk(2'd0, 0, 0, 0, O_RUN,   S_FL),
                mk(2'd0, 0, 0, 0, O_RUN,   S_RUN)};
        for (int i = 0; i < 11; i++) begin
            drive(seq[i]);
            e = sb_q.pop_front();
            g = observed();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL redirect[%0d] got ctl=%b st=%0d exp ctl=%b st=%0d", i, g.ctl, g.st, e.ctl, e.st);
            end
            if (i == 2) begin
                checks++;
                if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
                    failures++;
                    $display("FAIL redirect_first_cnt got f=%0d s=%0d exp f=1 s=0", flush_cnt, stall_cnt);
                end
            end
        end
        checks++;
        if (flush_cnt !== 16'd3 || stall_cnt !== 16'd2) begin
            failures++;
            $display("FAIL redirect_end_cnt got f=%0d s=%0d exp f=3 s=2", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_halt();
        exp_t e, g;
        do_reset();
        // The halting edge itself is counted once; HLT cycles are not.
        drive(mk(2'd0, 0, 1, 1, O_HALT, S_RUN));
        e = sb_q.pop_front();
        g = observed();
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL halt_entry got ctl=%b st=%0d exp ctl=%b st=%0d", g.ctl, g.st, e.ctl, e.st);
        end
        for (int i = 0; i < 100; i++) begin
            drive(mk(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), O_HALT, S_HLT));
            e = sb_q.pop_front();
            g = observed();
            checks++;
            if (g !== e || stall_cnt !== 16'd1 || flush_cnt !== 16'd1) begin
                failures++;
                $display("FAIL halt_hold[%0d] got ctl=%b st=%0d s=%0d f=%0d exp ctl=%b st=%0d s=1 f=1",
                         i, g.ctl, g.st, stall_cnt, flush_cnt, e.ctl, e.st);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({pc_we, ifid_we, ifid_flush, idex_flush, state} !== {O_RUN, S_RUN} || stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL halt_reset got ctl=%b st=%0d s=%0d exp ctl=%b st=0 s=0",
                     {pc_we, ifid_we, ifid_flush, idex_flush}, state, stall_cnt, O_RUN);
        end
        @(negedge clk);
        rst = 1'b0; bubble = 2'd0; redirect = 1'b0; md_busy = 1'b0; halt = 1'b0;
    endtask

    task automatic test_saturate();
        exp_t e, g;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(mk(2'd0, 0, 1, 0, O_STALL, (i == 0) ? S_RUN : S_MD));
            e = sb_q.pop_front();
            g = observed();
            checks++;
            if (g !== e || stall_cnt4 !== 4'((i > 15) ? 15 : i)) begin
                failures++;
                $display("FAIL saturate[%0d] got ctl=%b st=%0d s4=%0d exp ctl=%b st=%0d s4=%0d",
                         i, g.ctl, g.st, stall_cnt4, e.ctl, e.st, (i > 15) ? 15 : i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(mk(2'd0, 0, 1, 0, O_STALL, S_MD));
            e = sb_q.pop_front();
            g = observed();
            checks++;
            if (g !== e || stall_cnt4 !== 4'd15 || stall_cnt !== 16'(20 + i)) begin
                failures++;
                $display("FAIL saturate_hold[%0d] got st=%0d s4=%0d s=%0d exp st=%0d s4=15 s=%0d",
                         i, g.st, stall_cnt4, stall_cnt, e.st, 20 + i);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e, g;
        do_reset();
        drive(mk(2'd0, 0, 1, 0, O_STALL, S_RUN));
        void'(sb_q.pop_front());
        drive(mk(2'd0, 0, 1, 0, O_STALL, S_MD));
        e = sb_q.pop_front();
        g = observed();
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL areset_pre got ctl=%b st=%0d exp ctl=%b st=%0d", g.ctl, g.st, e.ctl, e.st);
        end
        // Pulse reset between edges while md_busy is still requesting.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({pc_we, state, stall_cnt, flush_cnt} !== {1'b1, S_RUN, 16'd0, 16'd0}) begin
            failures++;
            $display("FAIL areset_now got pc_we=%b st=%0d s=%0d f=%0d exp pc_we=1 st=0 s=0 f=0",
                     pc_we, state, stall_cnt, flush_cnt);
        end
        #1;
        rst = 1'b0;
        drive(mk(2'd0, 0, 1, 0, O_STALL, S_RUN));
        e = sb_q.pop_front();
        g = observed();
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL areset_post got ctl=%b st=%0d exp ctl=%b st=%0d", g.ctl, g.st, e.ctl, e.st);
        end
        drive(mk(2'd0, 0, 0, 0, O_RUN, S_MD));
        e = sb_q.pop_front();
        g = observed();
        checks++;
        if (g !== e || stall_cnt !== 16'd1) begin
            failures++;
            $display("FAIL areset_resume got ctl=%b st=%0d s=%0d exp ctl=%b st=%0d s=1",
                     g.ctl, g.st, stall_cnt, e.ctl, e.st);
        end
    endtask

    initial begin
        rst = 1'b1; bubble = 2'd0; redirect = 1'b0; md_busy = 1'b0; halt = 1'b0;
        test_reset();
        test_bubble();
        test_md();
        test_redirect();
        test_halt();
        test_saturate();
        test_async_reset();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
